uart_msg_arbiter: RTL and testbench

- Shares one `string_writer` (and its UART TX) among NUM_REQ message sources using round-robin arbitration.
- Each source presents a packed, null-terminated line: first char in bits [7:0], terminated by the first 0x00 byte.
- The arbiter latches the granted line and drives the writer's send/ready handshake.
- It acks the source once the writer has accepted the whole line.
- Sits between the status/debug producers (SD card FSM, etc.) and the single `string_writer` instance.

---
 rtl/uart_msg_arbiter_if.sv | 28 ++
 rtl/uart_msg_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_msg_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_arbiter_if.sv
// Requester and string_writer signals of uart_msg_arbiter.
// The master modport is the arbiter's view; slave is the environment's.
interface uart_msg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LINE_W  = 640
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*LINE_W-1:0] line_in;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic                      busy;
  logic [IdW-1:0]            grant_id;
  logic [LINE_W-1:0]         wr_line;
  logic                      wr_send;
  logic                      wr_ready;

  modport master (
    input  req, line_in, wr_ready,
    output ack, err, busy, grant_id, wr_line, wr_send
  );

  modport slave (
    output req, line_in, wr_ready,
    input  ack, err, busy, grant_id, wr_line, wr_send
  );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one string_writer among NUM_REQ line sources.
// Define UART_ARB_TIMEOUT_EN to enable the per-message watchdog (err on abort).
module uart_msg_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned LINE_W         = 640,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                clk,
  input logic                rst,
  uart_msg_arbiter_if.master bus
);
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StAck} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    last_q, grant_q, sel_idx, cand;
  logic              sel_valid;
  logic [LINE_W-1:0] line_q, sel_line;
  logic [LINE_W-1:0] lines [NUM_REQ];
  logic [NUM_REQ-1:0] ack;
  logic              err;
  logic              timeout;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lines
    assign lines[i] = bus.line_in[i*LINE_W +: LINE_W];
  end

  // First requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_q) + k) % NUM_REQ);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_line = lines[sel_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= IdW'(NUM_REQ - 1);
      grant_q <= '0;
      line_q  <= '0;
    end else if (state_q == StIdle && sel_valid) begin
      last_q  <= sel_idx;
      grant_q <= sel_idx;
      line_q  <= sel_line;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            in_txn;

  assign in_txn  = (state_q == StIssue) || (state_q == StWaitBusy) || (state_q == StWaitDone);
  assign timeout = in_txn && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero in IDLE, so it starts from zero on entering ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (in_txn) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      err_q <= timeout;
    end
  end

  assign err = err_q && (state_q == StAck);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Empty strings are acked without ever reaching the writer.
        if (sel_valid) state_d = (sel_line[7:0] == 8'h00) ? StAck : StIssue;
      end
      StIssue:    if (bus.wr_ready)  state_d = StWaitBusy;
      StWaitBusy: if (!bus.wr_ready) state_d = StWaitDone;
      StWaitDone: if (bus.wr_ready)  state_d = StAck;
      StAck:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (timeout) state_d = StAck;
  end

  always_comb begin
    ack = '0;
    if (state_q == StAck) ack[grant_q] = 1'b1;
  end

  assign bus.ack      = ack;
  assign bus.err      = err;
  assign bus.busy     = (state_q != StIdle);
  assign bus.wr_send  = (state_q == StIssue);
  assign bus.grant_id = grant_q;
  assign bus.wr_line  = line_q;
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter: a transaction-level model checked every cycle,
// plus hand-computed latencies, grant orders and line values.
module tb_uart_msg_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned LW = 640;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_msg_arbiter_if #(.NUM_REQ(NR), .LINE_W(LW)) bus ();

  uart_msg_arbiter #(
    .NUM_REQ        (NR),
    .LINE_W         (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic checki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one message in flight, tracked by what has happened to it so far.
  bit              m_act, m_ackc, m_err, m_empty, m_sent, m_low;
  int              m_src, m_last, m_age;
  logic [LW-1:0]   m_line;

  task automatic model_step(input logic r, input logic [NR-1:0] rq,
                            input logic [NR*LW-1:0] lines, input logic rdy);
    bit found;
    bit to_hit;
    int idx;
    if (r) begin
      m_act = 0; m_ackc = 0; m_err = 0; m_src = 0; m_last = NR - 1; m_line = '0;
    end else if (m_ackc) begin
      m_ackc = 0; m_err = 0; m_act = 0;
    end else if (!m_act) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (!found && rq[idx]) begin
          found = 1;
          m_src = idx;
        end
      end
      if (found) begin
        m_last  = m_src;
        m_line  = LW'(lines >> (m_src * LW));
        m_act   = 1;
        m_empty = (m_line[7:0] == 8'h00);
        m_sent  = 0; m_low = 0; m_age = 0;
        m_ackc  = m_empty;
      end
    end else begin
      to_hit = 0;
`ifdef UART_ARB_TIMEOUT_EN
      to_hit = (m_age == TO - 1);
`endif
      if (to_hit) begin
        m_ackc = 1; m_err = 1;
      end else if (!m_sent) m_sent = rdy;
      else if (!m_low) m_low = !rdy;
      else if (rdy) m_ackc = 1;
      m_age++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, bus.req, bus.line_in, bus.wr_ready);
      @(negedge clk);
      checki("busy",     int'(bus.busy),     int'(m_act));
      checki("wr_send",  int'(bus.wr_send),  int'(m_act && !m_empty && !m_sent && !m_ackc));
      checki("ack",      int'(bus.ack),      m_ackc ? (1 << m_src) : 0);
      checki("err",      int'(bus.err),      int'(m_ackc && m_err));
      checki("grant_id", int'(bus.grant_id), m_src);
      checkw("wr_line",  bus.wr_line,        m_line);
    end
  end

  // Writer model and source behaviour, applied at each falling edge.
  bit  w_auto     = 1;
  bit  auto_drop  = 1;
  int  w_busy_len = 3;
  int  w_cnt      = 0;
  bit  pend_send  = 0;
  int  s_cnt      = 0;

  task automatic tick();
    @(negedge clk);
    if (w_auto) begin
      if (pend_send && bus.wr_ready) begin
        bus.wr_ready = 1'b0;
        w_cnt = w_busy_len;
      end else if (w_cnt > 0) begin
        w_cnt--;
        if (w_cnt == 0) bus.wr_ready = 1'b1;
      end
    end
    if (auto_drop) bus.req = bus.req & ~bus.ack;
    pend_send = bus.wr_send;
    if (bus.wr_send) s_cnt++;
  endtask

  task automatic wait_ack(input int budget, output int n, output logic [NR-1:0] a);
    n = 0;
    a = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.ack != '0) begin
        n = i;
        a = bus.ack;
        break;
      end
    end
    if (n == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_wait: got no ack expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    int exp_order [5];
    logic [NR-1:0] a;
    bit all_busy;

    exp_order = '{0, 1, 2, 3, 0};
    bus.req      = '0;
    bus.line_in  = '0;
    bus.wr_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checki("rst_busy",  int'(bus.busy), 0);
    checki("rst_grant", int'(bus.grant_id), 0);
    checkw("rst_line",  bus.wr_line, '0);
    rst = 1'b0;
    tick();

    // Single request "HI".
    bus.line_in[0 +: LW] = LW'(16'h4948);
    s_cnt = 0;
    bus.req = 4'b0001;
    wait_ack(40, n, a);
    checki("t1_latency", n, 6);
    checki("t1_ack", int'(a), 1);
    checki("t1_sends", s_cnt, 1);
    checki("t1_gid", int'(bus.grant_id), 0);
    checkw("t1_line", bus.wr_line, LW'(16'h4948));
    tick();
    tick();

    // Empty line on source 2.
    bus.line_in[2*LW +: LW] = '0;
    s_cnt = 0;
    bus.req = 4'b0100;
    wait_ack(10, n, a);
    checki("empty_latency", n, 1);
    checki("empty_ack", int'(a), 4);
    checki("empty_sends", s_cnt, 0);
    tick();

    // Fairness with all sources held high from a fresh reset.
    bus.line_in[1*LW +: LW] = LW'(8'h41);
    bus.line_in[2*LW +: LW] = LW'(8'h42);
    bus.line_in[3*LW +: LW] = LW'(8'h43);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    auto_drop = 0;
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_ack(40, n, a);
      checki("fair_onehot", $countones(a), 1);
      checki("fair_order", int'(a), 1 << exp_order[r]);
    end
    bus.req = '0;
    auto_drop = 1;
    tick();
    tick();

    // Writer not ready for the first cycles of ISSUE.
    w_auto = 0;
    bus.wr_ready = 1'b0;
    s_cnt = 0;
    bus.req = 4'b1000;
    for (int i = 0; i < 6; i++) tick();
    checki("nr_send_held", int'(bus.wr_send), 1);
    bus.wr_ready = 1'b1;
    tick();
    checki("nr_send_drop", int'(bus.wr_send), 0);
    checki("nr_busy", int'(bus.busy), 1);
    checki("nr_sends", s_cnt, 6);
    bus.wr_ready = 1'b0;
    tick();
    bus.wr_ready = 1'b1;
    wait_ack(5, n, a);
    checki("nr_latency", n, 1);
    checki("nr_ack", int'(a), 8);
    w_auto = 1;
    tick();

    // Reset while waiting for the writer to finish.
    w_busy_len = 20;
    bus.req = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    bus.req = '0;
    tick();
    checki("rstmid_busy", int'(bus.busy), 0);
    checki("rstmid_ack", int'(bus.ack), 0);
    rst = 1'b0;
    for (int i = 0; i < 40 && !bus.wr_ready; i++) tick();
    checki("rstmid_writer_done", int'(bus.wr_ready), 1);
    w_busy_len = 3;
    bus.req = 4'b0011;
    wait_ack(40, n, a);
    checki("rstmid_first", int'(a), 1);
    wait_ack(40, n, a);
    checki("rstmid_second", int'(a), 2);
    tick();

    // Writer stuck low.
    w_auto = 0;
    bus.wr_ready = 1'b0;
    bus.req = 4'b0100;
`ifdef UART_ARB_TIMEOUT_EN
    wait_ack(40, n, a);
    checki("to_latency", n, 17);
    checki("to_ack", int'(a), 4);
    checki("to_err", int'(bus.err), 1);
`else
    all_busy = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.busy || bus.ack != '0) all_busy = 0;
    end
    checki("stuck_busy", int'(all_busy), 1);
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
`endif
    bus.wr_ready = 1'b1;
    w_auto = 1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
